// File: rtl/ror_pkg.sv
// Shared types and default sizing for the sequential rotate-right block.
package ror_pkg;

  localparam int unsigned RorWidth = 32;
  localparam int unsigned RorAmtW  = 5;

  typedef enum logic [1:0] {
    StIdle,
    StRotate,
    StDone
  } ror_state_e;

endpackage

// File: rtl/ror_seq.sv
// Sequential rotate-right: shifts the captured operand right by one bit per clock for N clocks,
// then publishes the result with a one-cycle done pulse.
module ror_seq
  import ror_pkg::*;
#(
  parameter int unsigned WIDTH = RorWidth,
  parameter int unsigned AMT_W = RorAmtW  // WIDTH must equal 2**AMT_W
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AMT_W-1:0] num_rotate,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             done
);

  ror_state_e       state_q, state_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] dout_q, dout_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    dout_d  = dout_q;

    unique case (state_q)
      StIdle: state_d = StIdle;
      StRotate: begin
        work_d = {work_q[0], work_q[WIDTH-1:1]};
        cnt_d  = cnt_q - AMT_W'(1);
        // Last step: publish the final value on the same edge, never an intermediate one.
        if (cnt_q == AMT_W'(1)) begin
          state_d = StDone;
          dout_d  = work_d;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Accept in IDLE or DONE; DONE with start high gives back-to-back operation.
    if (start && (state_q != StRotate)) begin
      work_d = data_in;
      cnt_d  = num_rotate;
      if (num_rotate == '0) begin
        state_d = StDone;
        dout_d  = data_in;
      end else begin
        state_d = StRotate;
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      work_q  <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      dout_q  <= dout_d;
    end
  end

  assign data_out = dout_q;
  assign busy     = (state_q == StRotate);
  assign done     = (state_q == StDone);

endmodule
